// File: rtl/truth_table_engine_if.sv
// truth_table_engine_if: evaluation, serial-load and sweep signals of the truth table engine
interface truth_table_engine_if #(parameter int N_IN = 3);
  logic [N_IN-1:0] in_vec;
  logic in_valid;
  logic out;
  logic out_valid;
  logic ld_en;
  logic ld_bit;
  logic ld_done;
  logic busy;
  logic sweep_start;
  logic sweep_out;
  logic [N_IN-1:0] sweep_idx;
  logic sweep_valid;
  logic sweep_done;
  modport master (
    output in_vec, in_valid, ld_en, ld_bit, sweep_start,
    input out, out_valid, ld_done, busy, sweep_out, sweep_idx, sweep_valid, sweep_done
  );
  modport slave (
    input in_vec, in_valid, ld_en, ld_bit, sweep_start,
    output out, out_valid, ld_done, busy, sweep_out, sweep_idx, sweep_valid, sweep_done
  );
endinterface

// File: rtl/truth_table_engine.sv
// truth_table_engine: programmable N_IN-input truth table with serial load and optional sweep (TT_SWEEP_EN)
module truth_table_engine #(
  parameter int N_IN = 3,
  parameter logic [(1<<N_IN)-1:0] TT_INIT = 'h2A
) (
  input logic clk,
  input logic rst_n,
  truth_table_engine_if.slave bus
);
  localparam int D = 1 << N_IN;
  localparam logic [N_IN:0] LAST = (N_IN+1)'(D - 1);
  localparam logic [N_IN:0] SW_END = (N_IN+1)'(D);
  localparam logic [N_IN:0] ONE = (N_IN+1)'(1);
  typedef enum logic [1:0] {IDLE, LOAD, SWEEP} state_t;
  state_t state;
  logic [D-1:0] active, shadow, shadow_nxt;
  logic [N_IN:0] ld_cnt, sw_cnt;
  logic [N_IN-1:0] sw_pos;
  logic sweep_go;
  assign sw_pos = sw_cnt[N_IN-1:0];
  assign bus.busy = state != IDLE;
`ifdef TT_SWEEP_EN
  assign sweep_go = bus.sweep_start && ld_cnt == '0;
`else
  // SWEEP is unreachable, so the sweep outputs never leave their reset value of 0
  assign sweep_go = 1'b0;
`endif
  // shadow with the incoming serial bit merged in, so the D-th bit commits in the same edge
  always_comb begin
    shadow_nxt = shadow;
    shadow_nxt[ld_cnt[N_IN-1:0]] = bus.ld_bit;
  end
  // evaluation path, independent of load/sweep state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out <= 1'b0;
      bus.out_valid <= 1'b0;
    end else begin
      bus.out_valid <= bus.in_valid;
      if (bus.in_valid) bus.out <= active[bus.in_vec];
    end
  end
  // load/sweep controller; sweep entries are emitted from the accept edge onward
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      active <= TT_INIT;
      shadow <= '0;
      ld_cnt <= '0;
      sw_cnt <= '0;
      bus.ld_done <= 1'b0;
      bus.sweep_out <= 1'b0;
      bus.sweep_idx <= '0;
      bus.sweep_valid <= 1'b0;
      bus.sweep_done <= 1'b0;
    end else begin
      bus.ld_done <= 1'b0;
      case (state)
        IDLE, LOAD: begin
          if (bus.ld_en) begin
            if (ld_cnt == LAST) begin
              active <= shadow_nxt;
              shadow <= '0;
              ld_cnt <= '0;
              bus.ld_done <= 1'b1;
              state <= IDLE;
            end else begin
              shadow <= shadow_nxt;
              ld_cnt <= ld_cnt + 1'b1;
              state <= LOAD;
            end
          end else if (state == IDLE && sweep_go) begin
            state <= SWEEP;
            sw_cnt <= ONE;
            bus.sweep_valid <= 1'b1;
            bus.sweep_idx <= '0;
            bus.sweep_out <= active[0];
            bus.sweep_done <= D == 1;
          end
        end
        SWEEP: begin
          if (sw_cnt == SW_END) begin
            state <= IDLE;
            bus.sweep_valid <= 1'b0;
            bus.sweep_done <= 1'b0;
          end else begin
            bus.sweep_idx <= sw_pos;
            bus.sweep_out <= active[sw_pos];
            bus.sweep_done <= sw_cnt == LAST;
            sw_cnt <= sw_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_truth_table_engine.sv
// tb_truth_table_engine: directed and random stimulus against a behavioural table model
module tb_truth_table_engine;
  localparam int N = 3;
  localparam int D = 8;
`ifdef TT_SWEEP_EN
  localparam bit SW = 1'b1;
`else
  localparam bit SW = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  truth_table_engine_if #(.N_IN(N)) bus();
  truth_table_engine #(.N_IN(N), .TT_INIT(8'h2A)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  always #5 clk = ~clk;
  int n_chk = 0;
  int n_pass = 0;
  bit [D-1:0] m_tbl, m_sh;
  int m_cnt, m_sw, m_sidx;
  bit m_out, m_ov, m_done, m_sout;
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask
  task automatic model_reset();
    m_tbl = 8'h2A;
    m_sh = '0;
    m_cnt = 0;
    m_sw = -1;
    m_sidx = 0;
    m_out = 0;
    m_ov = 0;
    m_done = 0;
    m_sout = 0;
  endtask
  task automatic compare();
    check("out", bus.out, m_out);
    check("out_valid", bus.out_valid, m_ov);
    check("ld_done", bus.ld_done, m_done);
    check("busy", bus.busy, m_cnt > 0 || m_sw >= 0);
    check("sweep_valid", bus.sweep_valid, m_sw >= 0);
    check("sweep_done", bus.sweep_done, m_sw == D - 1);
    check("sweep_idx", bus.sweep_idx, m_sidx);
    check("sweep_out", bus.sweep_out, m_sout);
  endtask
  // one clock: advance the model with the inputs seen at the edge, then compare
  task automatic cycle();
    @(posedge clk);
    m_ov = bus.in_valid;
    if (bus.in_valid) m_out = m_tbl[bus.in_vec];
    m_done = 0;
    if (m_sw >= 0) m_sw = (m_sw == D - 1) ? -1 : m_sw + 1;
    else if (bus.ld_en) begin
      m_sh[m_cnt] = bus.ld_bit;
      m_cnt++;
      if (m_cnt == D) begin
        m_tbl = m_sh;
        m_cnt = 0;
        m_done = 1;
      end
    end else if (SW && m_cnt == 0 && bus.sweep_start) m_sw = 0;
    if (m_sw >= 0) begin
      m_sidx = m_sw;
      m_sout = m_tbl[m_sw];
    end
    #1 compare();
  endtask
  task automatic drive(bit iv, bit [N-1:0] v, bit le, bit lb, bit ss);
    bus.in_valid = iv;
    bus.in_vec = v;
    bus.ld_en = le;
    bus.ld_bit = lb;
    bus.sweep_start = ss;
    cycle();
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    compare();
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask
  task automatic load_byte(bit [D-1:0] v);
    for (int k = 0; k < D; k++) drive(0, 0, 1, v[k], 0);
  endtask
  initial begin
    bit [D-1:0] pat;
    bus.in_valid = 0;
    bus.in_vec = '0;
    bus.ld_en = 0;
    bus.ld_bit = 0;
    bus.sweep_start = 0;
    model_reset();
    #2 compare();
    @(posedge clk);
    #1 rst_n = 1'b1;
    drive(1, 1, 0, 0, 0); check("tp_reset_eval1", bus.out, 1);
    drive(1, 2, 0, 0, 0); check("tp_reset_eval2", bus.out, 0);
    drive(1, 3, 0, 0, 0); check("tp_reset_eval3", bus.out, 1);
    drive(1, 5, 0, 0, 0); check("tp_reset_eval5", bus.out, 1);
    drive(0, 0, 0, 0, 0); check("tp_out_hold", bus.out_valid, 0);
    load_byte(8'h96);
    check("tp_ld_done", bus.ld_done, 1);
    drive(1, 0, 0, 0, 0); check("tp_new_eval0", bus.out, 0);
    drive(1, 1, 0, 0, 0); check("tp_new_eval1", bus.out, 1);
    drive(1, 7, 0, 0, 0); check("tp_new_eval7", bus.out, 1);
    pat = 8'h2A;
    for (int k = 0; k < 4; k++) drive(0, 0, 1, pat[k], 0);
    for (int k = 0; k < 3; k++) begin
      drive(1, 1, 0, 0, 0);
      check("tp_gap_old_table", bus.out, 1);
      check("tp_gap_busy", bus.busy, 1);
    end
    for (int k = 4; k < D; k++) drive(0, 0, 1, pat[k], 0);
    check("tp_gap_commit", bus.ld_done, 1);
    drive(0, 0, 0, 0, 1);
    for (int k = 0; k < D + 2; k++) drive(k % 2 == 0, 3'(k), k == 2, 1, k == 4);
    drive(0, 0, 1, 1, 1);
    check("tp_conflict_busy", bus.busy, 1);
    check("tp_conflict_nosweep", bus.sweep_valid, 0);
    for (int k = 0; k < 4; k++) drive(0, 0, 1, 0, 0);
    do_reset();
    check("tp_rst_busy", bus.busy, 0);
    drive(1, 1, 0, 0, 0); check("tp_rst_eval1", bus.out, 1);
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(499) == 0) do_reset();
      drive(1'($urandom), 3'($urandom), $urandom_range(3) == 0, 1'($urandom), $urandom_range(15) == 0);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/truth_table_engine.md
# truth_table_engine

Parametrised, programmable N-input Boolean truth-table evaluator for the gate-level circuit library. It holds a 2^N_IN-bit truth table, evaluates input vectors with one-cycle registered latency, and accepts a new table over a serial load port without disturbing evaluation. An optional sweep mode streams every table entry in index order so testbenches and characterisation flows can dump the implemented function.

## Interface
- N_IN, 3: number of Boolean inputs; legal range 1..8. Table depth D = 2^N_IN.
- TT_INIT, 'h2A (D bits): table value after reset. Bit k is the output for input vector value k.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_vec  in  N_IN  input vector; value k selects table bit k
- in_valid  in  1  evaluate in_vec this cycle
- out  out  1  registered table output
- out_valid  out  1  qualifies out
- ld_en  in  1  shift ld_bit into the shadow table this cycle
- ld_bit  in  1  serial table data, bit 0 first
- ld_done  out  1  one-cycle pulse: shadow committed to active table
- busy  out  1  high while a load is partial or a sweep is running
- sweep_start  in  1  start a sweep (level sampled, acted on in IDLE only)
- sweep_out  out  1  table bit at sweep_idx
- sweep_idx  out  N_IN  index of current sweep entry
- sweep_valid  out  1  qualifies sweep_out/sweep_idx
- sweep_done  out  1  high with the last sweep entry (idx D-1)

## Operation
- States: IDLE, LOAD, SWEEP. Reset -> IDLE.
- Evaluation is independent of state: when in_valid=1, next cycle out = active_table[in_vec], out_valid=1; when in_valid=0, out_valid=0 next cycle, out holds last value.
- Load: ld_en=1 in IDLE or LOAD shifts ld_bit into shadow[ld_cnt], ld_cnt increments, state = LOAD. ld_en=0 in LOAD holds ld_cnt and shadow (pause, no abort).
- On the D-th shifted bit: active_table <= shadow, ld_cnt <= 0, ld_done=1 for one cycle, state -> IDLE. Evaluation uses the old table up to and including the commit cycle; first eval sampled the cycle after ld_done uses the new table.
- Sweep: sweep_start=1 in IDLE with ld_cnt=0 -> SWEEP. Each SWEEP cycle emits sweep_idx = i, sweep_out = active_table[i], sweep_valid=1, for i = 0..D-1 consecutively; sweep_done=1 with i=D-1; then IDLE.
- Conflicts: ld_en and sweep_start both high in IDLE -> load wins, sweep_start dropped. sweep_start in LOAD or SWEEP ignored. ld_en in SWEEP ignored (bit discarded, ld_cnt unchanged).
- busy = (state != IDLE).
- Index arithmetic is N_IN+1 bits internally so D-1 terminal detection has no wrap ambiguity; sweep_idx is the low N_IN bits.

## Timing
- Reset values: out=0, out_valid=0, ld_done=0, busy=0, sweep_out=0, sweep_idx=0, sweep_valid=0, sweep_done=0; active_table=TT_INIT, shadow=0, ld_cnt=0.
- Eval latency 1 cycle, throughput 1/cycle, all states.
- Load: D ld_en cycles minimum; ld_done asserts in the cycle after the D-th ld_en edge is registered (registered output).
- Sweep: first sweep_valid the cycle after sweep_start is accepted; D consecutive valid cycles; busy drops the cycle after sweep_done.
- Reset mid-load discards shadow and restores TT_INIT; reset mid-sweep terminates with no sweep_done.

## Configuration
- TT_SWEEP_EN defined: sweep logic and SWEEP state compiled in as above.
- Undefined: SWEEP unreachable, sweep_start ignored, sweep_out/sweep_idx/sweep_valid/sweep_done tied 0; ports remain for pin compatibility; eval and load unchanged.

## Test plan
- Reset, N_IN=3: in_vec=1,2,3,5 with in_valid -> out=1,0,1,1 one cycle later (TT_INIT 'h2A).
- Load 0x96 as ld_bit 0,1,1,0,1,0,0,1 -> ld_done pulse after 8th bit; then in_vec=0,1,7 -> out=0,1,1.
- Load with 3-cycle ld_en gap after bit 4, eval in_vec=1 during gap -> out=1 (old table); commit occurs after bit 8 only.
- TT_SWEEP_EN, table 'h2A: sweep_start -> 8 cycles sweep_out=0,1,0,1,0,1,0,0, sweep_done with idx 7, busy low next cycle.
- ld_en and sweep_start same cycle in IDLE -> LOAD entered, no sweep_valid; sweep_start during SWEEP -> no restart.
- rst_n low after 5 load bits -> ld_cnt=0, in_vec=1 gives out=1 (TT_INIT), busy=0.
